// File: rtl/led_pattern_seq_if.sv
// Switch/LED bundle of the pattern sequencer.
// The lab top level drives the switch inputs; the sequencer drives the LED outputs.
interface led_pattern_seq_if #(
    parameter int N_LEDS = 8,
    parameter int NB_SEL = 2
);
    logic              i_enable;
    logic [NB_SEL-1:0] i_sel;
    logic [1:0]        i_mode;
    logic              i_color;
    logic [N_LEDS-1:0] o_led;
    logic [N_LEDS-1:0] o_led_b;
    logic [N_LEDS-1:0] o_led_g;
    logic              o_tick;

    modport master (
        output i_enable, i_sel, i_mode, i_color,
        input  o_led, o_led_b, o_led_g, o_tick
    );

    modport slave (
        input  i_enable, i_sel, i_mode, i_color,
        output o_led, o_led_b, o_led_g, o_tick
    );
endinterface

// File: rtl/led_pattern_seq.sv
// Multi-mode LED pattern sequencer: a prescaler with a switch-selected limit
// produces step events that rotate, bounce or blink an N_LEDS-wide pattern.
module led_pattern_seq #(
    parameter int N_LEDS     = 8,
    parameter int NB_COUNT   = 32,
    parameter int NB_SEL     = 2,
    parameter int LIMIT_BASE = 22
) (
    input  logic            clock,
    input  logic            i_reset,
    led_pattern_seq_if.slave bus
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        MODE_ROT_L = 2'b00,
        MODE_ROT_R = 2'b01,
        MODE_PONG  = 2'b10,
        MODE_FLASH = 2'b11
    } mode_e;

    localparam logic [NB_COUNT-1:0] COUNT_ONES = '1;
    localparam logic [NB_COUNT-1:0] COUNT_ONE  = NB_COUNT'(1);
    localparam logic [N_LEDS-1:0]   PAT_ONE    = N_LEDS'(1);
    localparam logic [N_LEDS-1:0]   PAT_ALL    = '1;

    logic [NB_COUNT-1:0] counter_q, counter_d;
    logic [N_LEDS-1:0]   pattern_q, pattern_d;
    dir_e                dir_q, dir_d;
    mode_e               mode_q, mode_d;
    logic                tick_q, tick_d;

    logic [NB_COUNT-1:0] limit;
    logic                step;

    // limit k has LIMIT_BASE+k low ones; i_sel is live, so a shrinking limit steps at once.
    always_comb begin
        limit = COUNT_ONES >> (NB_COUNT - LIMIT_BASE - int'(bus.i_sel));
        step  = bus.i_enable && (counter_q >= limit);
    end

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        counter_d = counter_q;
        pattern_d = pattern_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        tick_d    = 1'b0;

        if (bus.i_enable) begin
            if (step) begin
                counter_d = '0;
                tick_d    = 1'b1;
                if (mode_e'(bus.i_mode) != mode_q) begin
                    // A new mode restarts cleanly instead of advancing the old pattern.
                    mode_d    = mode_e'(bus.i_mode);
                    dir_d     = DIR_UP;
                    pattern_d = (mode_e'(bus.i_mode) == MODE_FLASH) ? PAT_ALL : PAT_ONE;
                end else begin
                    case (mode_q)
                        MODE_ROT_L: pattern_d = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
                        MODE_ROT_R: pattern_d = {pattern_q[0], pattern_q[N_LEDS-1:1]};
                        MODE_PONG: begin
                            if (dir_q == DIR_UP) begin
                                pattern_d = pattern_q << 1;
                                if (pattern_d[N_LEDS-1]) dir_d = DIR_DOWN;
                            end else begin
                                pattern_d = pattern_q >> 1;
                                if (pattern_d[0]) dir_d = DIR_UP;
                            end
                        end
                        default: pattern_d = ~pattern_q;
                    endcase
                end
            end else begin
                counter_d = counter_q + COUNT_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            counter_q <= '0;
            pattern_q <= PAT_ONE;
            dir_q     <= DIR_UP;
            mode_q    <= MODE_ROT_L;
            tick_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.o_led   = pattern_q;
    assign bus.o_led_b = bus.i_color ? '0 : pattern_q;
    assign bus.o_led_g = bus.i_color ? pattern_q : '0;
    assign bus.o_tick  = tick_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq (4 LEDs, limits 3/7/15/31): expected
// patterns are queued as stimulus is applied and popped on each o_tick.
module tb_led_pattern_seq;

    logic clock = 1'b0;
    logic i_reset;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];
    logic [3:0] seq[$];

    led_pattern_seq_if #(.N_LEDS(4), .NB_SEL(2)) bus ();

    led_pattern_seq #(
        .N_LEDS    (4),
        .NB_COUNT  (32),
        .NB_SEL    (2),
        .LIMIT_BASE(2)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_edge();
        @(posedge clock);
        #1;
    endtask

    // Waits (bounded) for the next o_tick, checks its spacing and the queued pattern.
    task automatic expect_tick(input string tag, input int exp_gap);
        int         gap  = 0;
        bit         seen = 1'b0;
        logic [3:0] exp;
        while (!seen && gap < 64) begin
            tick_edge();
            gap++;
            if (bus.o_tick === 1'b1) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) check({tag, "_gap"}, 32'(gap), 32'(exp_gap));
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, "_led"}, 32'(bus.o_led), 32'(exp));
        end else begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end
    endtask

    task automatic push_seq();
        foreach (seq[i]) exp_q.push_back(seq[i]);
    endtask

    task automatic play(input string tag, input int n, input int gap);
        for (int i = 0; i < n; i++) expect_tick(tag, gap);
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        tick_edge();
        i_reset = 1'b0;
    endtask

    initial begin
        bit tick_seen;

        i_reset      = 1'b1;
        bus.i_enable = 1'b1;
        bus.i_sel    = 2'd0;
        bus.i_mode   = 2'b00;
        bus.i_color  = 1'b0;
        tick_edge();
        tick_edge();
        check("rst_led", 32'(bus.o_led), 32'h1);
        check("rst_tick", 32'(bus.o_tick), 32'h0);
        check("rst_cnt", dut.counter_q, 32'd0);
        i_reset = 1'b0;

        // T1: rotate left, tick every 4 cycles
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        push_seq();
        play("t1", 4, 4);
        tick_edge();
        check("t1_tick_1cyc", 32'(bus.o_tick), 32'h0);

        // T2: rotate right from reset state
        bus.i_mode = 2'b01;
        pulse_reset();
        seq = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        push_seq();
        play("t2", 5, 4);

        // T3: ping-pong
        bus.i_mode = 2'b10;
        pulse_reset();
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        push_seq();
        play("t3", 8, 4);

        // T4: flash and colour routing
        bus.i_mode  = 2'b11;
        bus.i_color = 1'b0;
        pulse_reset();
        seq = '{4'b1111};
        push_seq();
        expect_tick("t4a", 4);
        check("t4_b_blue", 32'(bus.o_led_b), 32'hf);
        check("t4_g_blue", 32'(bus.o_led_g), 32'h0);
        bus.i_color = 1'b1;
        #1;
        check("t4_b_green", 32'(bus.o_led_b), 32'h0);
        check("t4_g_green", 32'(bus.o_led_g), 32'hf);
        seq = '{4'b0000, 4'b1111};
        push_seq();
        expect_tick("t4b", 4);
        check("t4_g_off", 32'(bus.o_led_g), 32'h0);
        expect_tick("t4c", 4);
        check("t4_g_on", 32'(bus.o_led_g), 32'hf);

        // T5: limit drops below counter -> step on next edge
        bus.i_mode  = 2'b00;
        bus.i_color = 1'b0;
        bus.i_sel   = 2'd3;
        pulse_reset();
        tick_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick_edge();
            if (bus.o_tick === 1'b1) tick_seen = 1'b1;
        end
        check("t5_no_tick", 32'(tick_seen), 32'h0);
        check("t5_cnt20", dut.counter_q, 32'd20);
        bus.i_sel = 2'd0;
        seq = '{4'b0010};
        push_seq();
        expect_tick("t5_fast", 1);
        seq = '{4'b0100, 4'b1000};
        push_seq();
        play("t5", 2, 4);

        // T6: enable low freezes everything
        tick_edge();
        tick_edge();
        bus.i_enable = 1'b0;
        tick_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_edge();
            if (bus.o_tick === 1'b1) tick_seen = 1'b1;
        end
        check("t6_hold_tick", 32'(tick_seen), 32'h0);
        check("t6_hold_cnt", dut.counter_q, 32'd2);
        check("t6_hold_led", 32'(bus.o_led), 32'h8);
        bus.i_enable = 1'b1;
        seq = '{4'b0001, 4'b0010};
        push_seq();
        expect_tick("t6_resume", 2);
        expect_tick("t6_next", 4);

        // T6: reset while running discards position
        tick_edge();
        pulse_reset();
        check("t6_rst_led", 32'(bus.o_led), 32'h1);
        check("t6_rst_cnt", dut.counter_q, 32'd0);
        check("t6_rst_tick", 32'(bus.o_tick), 32'h0);
        seq = '{4'b0010};
        push_seq();
        expect_tick("t6_after", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
